rv_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the RV32I datapath: PC, register file, extend unit, ALU and result muxes.
- Datapath uses a single shared instruction/data memory port, so the controller issues one memory request per phase.
- Controller holds on a ready handshake and drives every mux select and write enable from a registered state plus the IR fields.
- Sits between the instruction register / memory interface and the datapath control inputs.

---
 rtl/rv_ctrl_pkg.sv | 83 ++++++++
 rtl/rv_alu_decoder.sv | 45 ++++
 rtl/rv_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller:
// FSM states, opcodes, ALU operations and datapath mux select codes.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StJal,
        StJalr,
        StJalrWb,
        StBranch,
        StUpper,
        StTrap
    } ctrl_state_e;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9
    } alu_op_e;

    // Which kind of operation the ALU decoder should derive from funct3/funct7.
    typedef enum logic [1:0] {
        AluClsAdd,
        AluClsOp,
        AluClsOpImm,
        AluClsBranch
    } alu_cls_e;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResData   = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmU = 3'b011;
    localparam logic [2:0] ImmJ = 3'b100;

    // BEQ/BGE/BGEU take on zero, BNE/BLT/BLTU on !zero (SUB or SLT/SLTU result).
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        return zero ^ funct3[0] ^ funct3[2];
    endfunction

    function automatic logic branch_funct3_valid(input logic [2:0] funct3);
        return funct3[2:1] != 2'b01;
    endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// Combinational ALU operation decode from instruction class, funct3 and funct7[5].
module rv_alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 6
) (
    input  alu_cls_e               alu_cls,
    input  logic [2:0]             funct3,
    input  logic                   funct7_5,
    output logic [ALU_CTRL_W-1:0]  alu_control
);

    alu_op_e alu_op;

    always_comb begin
        alu_op = AluAdd;
        unique case (alu_cls)
            AluClsAdd: alu_op = AluAdd;
            AluClsOp, AluClsOpImm: begin
                case (funct3)
                    // Immediate forms have no SUB; bit 30 is part of the immediate there.
                    3'b000:  alu_op = (alu_cls == AluClsOp && funct7_5) ? AluSub : AluAdd;
                    3'b001:  alu_op = AluSll;
                    3'b010:  alu_op = AluSlt;
                    3'b011:  alu_op = AluSltu;
                    3'b100:  alu_op = AluXor;
                    3'b101:  alu_op = funct7_5 ? AluSra : AluSrl;
                    3'b110:  alu_op = AluOr;
                    default: alu_op = AluAnd;
                endcase
            end
            AluClsBranch: begin
                case (funct3[2:1])
                    2'b00:   alu_op = AluSub;
                    2'b10:   alu_op = AluSlt;
                    2'b11:   alu_op = AluSltu;
                    default: alu_op = AluAdd;
                endcase
            end
        endcase
    end

    assign alu_control = ALU_CTRL_W'(alu_op);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// RV32I multi-cycle control FSM driving a shared-memory datapath.
// Optional macro RV_MISALIGN_TRAP_EN: misaligned SH/SW trap instead of issuing the store.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 6,
    parameter int unsigned MEM_STRB_W = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [31:0]            instr,
    input  logic                   zero,
    input  logic [1:0]             addr_lo,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   adr_src,
    output logic [MEM_STRB_W-1:0]  mem_w,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   reg_write,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [2:0]             imm_src,
    output logic [1:0]             result_src,
    output logic [ALU_CTRL_W-1:0]  alu_control,
    output logic                   instr_done,
    output logic                   illegal
);

    ctrl_state_e state_q, state_d;
    logic        illegal_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       is_store;
    logic       misaligned;
    logic       unused_instr;

    logic [MEM_STRB_W-1:0] store_strb;
    alu_cls_e              alu_cls;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7_5     = instr[30];
    assign is_store     = opcode == OpcStore;
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

`ifdef RV_MISALIGN_TRAP_EN
    assign misaligned = (funct3 == 3'b001 && addr_lo[0]) ||
                        (funct3 == 3'b010 && addr_lo != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Out-of-range strobe bits simply fall off the top of the bus.
    always_comb begin
        store_strb = '0;
        case (funct3)
            3'b000:  store_strb = MEM_STRB_W'(1) << addr_lo;
            3'b001:  store_strb = MEM_STRB_W'(3) << addr_lo;
            3'b010:  store_strb = '1;
            default: store_strb = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpcLoad, OpcStore: state_d = StMemAdr;
                    OpcOp:             state_d = StExecR;
                    OpcOpImm:          state_d = StExecI;
                    OpcJal:            state_d = StJal;
                    OpcJalr:           state_d = StJalr;
                    OpcBranch:         state_d = StBranch;
                    OpcLui, OpcAuipc:  state_d = StUpper;
                    default:           state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                if (!is_store)      state_d = StMemRead;
                else if (misaligned) state_d = StTrap;
                else                state_d = StMemWrite;
            end
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR, StExecI: state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StJal:    state_d = StAluWb;
            StJalr:   state_d = StJalrWb;
            StJalrWb: state_d = StFetch;
            StBranch: state_d = branch_funct3_valid(funct3) ? StFetch : StTrap;
            StUpper:  state_d = StFetch;
            StTrap:   state_d = StTrap;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= StIdle;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == StTrap) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_w      = '0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        imm_src    = ImmI;
        result_src = ResAluOut;
        instr_done = 1'b0;
        alu_cls    = AluClsAdd;
        unique case (state_q)
            StIdle: ;
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAlu;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                imm_src   = (opcode == OpcJal) ? ImmJ : ImmB;
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                imm_src   = is_store ? ImmS : ImmI;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                mem_w      = store_strb;
                instr_done = mem_ready;
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_cls   = AluClsOp;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_cls   = AluClsOpImm;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StJal: begin
                pc_write  = 1'b1;
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
            end
            StJalr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
            end
            StJalrWb: begin
                pc_write   = 1'b1;
                alu_src_a  = SrcAOldPc;
                alu_src_b  = SrcBFour;
                result_src = ResAlu;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a = SrcARs1;
                alu_cls   = AluClsBranch;
                if (branch_funct3_valid(funct3)) begin
                    pc_write   = branch_taken(funct3, zero);
                    instr_done = 1'b1;
                end
            end
            StUpper: begin
                alu_src_a  = (opcode == OpcLui) ? SrcAZero : SrcAOldPc;
                alu_src_b  = SrcBImm;
                imm_src    = ImmU;
                result_src = ResAlu;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StTrap: ;
        endcase
    end

    rv_alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .alu_cls     (alu_cls),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (alu_control)
    );

    assign illegal = illegal_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: per-cycle expected control words via a scoreboard queue.
module tb_rv_multicycle_ctrl;

    logic        clk;
    logic        arst_n;
    logic [31:0] instr;
    logic        zero;
    logic [1:0]  addr_lo;
    logic        mem_ready;
    logic        mem_req;
    logic        adr_src;
    logic [3:0]  mem_w;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  imm_src;
    logic [1:0]  result_src;
    logic [5:0]  alu_control;
    logic        instr_done;
    logic        illegal;

    logic [25:0] obs;
    logic [25:0] exp_q[$];
    string       tag_q[$];
    int          n_tests;
    int          n_fail;

    localparam logic [25:0] Z = 26'd0;

    rv_multicycle_ctrl #(
        .ALU_CTRL_W (6),
        .MEM_STRB_W (4)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .instr       (instr),
        .zero        (zero),
        .addr_lo     (addr_lo),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .adr_src     (adr_src),
        .mem_w       (mem_w),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .result_src  (result_src),
        .alu_control (alu_control),
        .instr_done  (instr_done),
        .illegal     (illegal)
    );

    assign obs = {mem_req, adr_src, mem_w, ir_write, pc_write, reg_write, alu_src_a, alu_src_b,
                  imm_src, result_src, alu_control, instr_done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1);
    end

    function automatic logic [25:0] ov(input logic mreq, input logic adr, input logic [3:0] mw,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] imm, input logic [1:0] res,
                                       input logic [5:0] alu, input logic done,
                                       input logic ill);
        return {mreq, adr, mw, irw, pcw, rw, a, b, imm, res, alu, done, ill};
    endfunction

    task automatic check();
        logic [25:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %07h required %07h", t, obs, e);
        end
    endtask

    // Expected word is queued with the stimulus, checked mid-cycle, then the clock advances.
    task automatic cyc(input string tag, input logic [25:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        #1 check();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_now(input string tag, input logic [25:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1 check();
    endtask

    task automatic front(input string name, input logic [31:0] ins, input logic [2:0] dec_imm);
        instr     = ins;
        mem_ready = 1'b1;
        cyc({name, "_fetch"}, ov(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 3'd0, 2'd2,
                                 6'd0, 1'b0, 1'b0));
        cyc({name, "_decode"}, ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, dec_imm, 2'd0,
                                  6'd0, 1'b0, 1'b0));
    endtask

    task automatic reset_pulse(input string name);
        arst_n = 1'b0;
        chk_now({name, "_async"}, Z);
        @(posedge clk);
        #1 arst_n = 1'b1;
        cyc({name, "_idle"}, Z);
    endtask

    logic [25:0] alu_wb;
    logic [25:0] mem_rd;
    logic [25:0] trapped;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        arst_n    = 1'b0;
        instr     = 32'h0;
        zero      = 1'b0;
        addr_lo   = 2'd0;
        mem_ready = 1'b0;
        alu_wb  = ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0, 2'd0, 6'd0, 1'b1, 1'b0);
        mem_rd  = ov(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 6'd0, 1'b0, 1'b0);
        trapped = ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 6'd0, 1'b0, 1'b1);

        @(posedge clk);
        chk_now("por", Z);
        #1 arst_n = 1'b1;
        cyc("por_idle", Z);

        instr = 32'h002081B3;
        cyc("fetch_wait", ov(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 3'd0, 2'd2, 6'd0,
                             1'b0, 1'b0));
        front("add", 32'h002081B3, 3'd2);
        cyc("add_exec", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd0, 2'd0, 6'd0,
                           1'b0, 1'b0));
        cyc("add_wb", alu_wb);

        front("sub", 32'h402081B3, 3'd2);
        cyc("sub_exec", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd0, 2'd0, 6'd1,
                           1'b0, 1'b0));
        cyc("sub_wb", alu_wb);

        front("srai", 32'h4030D093, 3'd2);
        cyc("srai_exec", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 2'd0, 6'd7,
                            1'b0, 1'b0));
        cyc("srai_wb", alu_wb);

        front("addi", 32'hC0000093, 3'd2);
        cyc("addi_exec", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 2'd0, 6'd0,
                            1'b0, 1'b0));
        cyc("addi_wb", alu_wb);

        front("lw", 32'h0000A183, 3'd2);
        cyc("lw_adr", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 2'd0, 6'd0,
                         1'b0, 1'b0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_wait", mem_rd);
        mem_ready = 1'b1;
        cyc("lw_ready", mem_rd);
        mem_ready = 1'b0;
        cyc("lw_wb", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0, 2'd1, 6'd0,
                        1'b1, 1'b0));

        addr_lo = 2'd3;
        front("sb", 32'h00208023, 3'd2);
        cyc("sb_adr", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd1, 2'd0, 6'd0,
                         1'b0, 1'b0));
        mem_ready = 1'b0;
        cyc("sb_wait", ov(1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 6'd0,
                          1'b0, 1'b0));
        mem_ready = 1'b1;
        cyc("sb_write", ov(1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 6'd0,
                           1'b1, 1'b0));
        addr_lo = 2'd0;

        zero = 1'b1;
        front("beq", 32'h00208063, 3'd2);
        cyc("beq_branch", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 3'd0, 2'd0, 6'd1,
                             1'b1, 1'b0));
        front("bne", 32'h00209063, 3'd2);
        cyc("bne_branch", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd0, 2'd0, 6'd1,
                             1'b1, 1'b0));
        zero = 1'b0;
        front("bltu", 32'h0020E063, 3'd2);
        cyc("bltu_branch", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 3'd0, 2'd0, 6'd9,
                              1'b1, 1'b0));
        front("bge", 32'h0020D063, 3'd2);
        cyc("bge_branch", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd0, 2'd0, 6'd8,
                             1'b1, 1'b0));

        front("jal", 32'h000000EF, 3'd4);
        cyc("jal_jump", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 3'd0, 2'd0, 6'd0,
                           1'b0, 1'b0));
        cyc("jal_wb", alu_wb);

        front("lui", 32'h000010B7, 3'd2);
        cyc("lui_upper", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1, 3'd3, 2'd2, 6'd0,
                            1'b1, 1'b0));
        front("auipc", 32'h00001097, 3'd2);
        cyc("auipc_upper", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 3'd3, 2'd2, 6'd0,
                              1'b1, 1'b0));

        addr_lo = 2'd2;
        front("sw", 32'h0020A023, 3'd2);
        cyc("sw_adr", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd1, 2'd0, 6'd0,
                         1'b0, 1'b0));
`ifdef RV_MISALIGN_TRAP_EN
        cyc("sw_trap", trapped);
        reset_pulse("sw_rst");
`else
        cyc("sw_write", ov(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 2'd0, 6'd0,
                           1'b1, 1'b0));
`endif
        addr_lo = 2'd0;

        // Reset in the middle of a load access.
        front("lw2", 32'h0000A183, 3'd2);
        cyc("lw2_adr", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd0, 2'd0, 6'd0,
                          1'b0, 1'b0));
        mem_ready = 1'b0;
        cyc("lw2_wait", mem_rd);
        reset_pulse("rd_rst");
        mem_ready = 1'b1;
        cyc("rd_rst_fetch", ov(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 3'd0, 2'd2, 6'd0,
                               1'b0, 1'b0));

        instr = 32'h0000007F;
        cyc("bad_decode", ov(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 3'd2, 2'd0, 6'd0,
                             1'b0, 1'b0));
        cyc("trap_entry", trapped);
        for (int i = 0; i < 20; i++) cyc("trap_hold", trapped);
        reset_pulse("trap_rst");
        cyc("trap_rst_fetch", ov(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 3'd0, 2'd2,
                                 6'd0, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
